spi_slave_burst_if: RTL

//  Parametrised SPI slave front-end for the SPI-to-RAM wrapper. Deserialises

---
 rtl/spi_slave_burst_if_pkg.sv | 19 +
 rtl/spi_slave_burst_if.sv | 136 +++++++++++++
 2 files changed

// File: rtl/spi_slave_burst_if_pkg.sv
// rtl/spi_slave_burst_if_pkg.sv - state encoding and command codes for the SPI slave burst front-end
package spi_slave_burst_if_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_CHK_CMD   = 3'd1;
   localparam state_t ST_WRITE     = 3'd2;
   localparam state_t ST_READ_ADD  = 3'd3;
   localparam state_t ST_READ_DATA = 3'd4;
   localparam state_t ST_TX        = 3'd5;
   localparam state_t ST_WAIT_SS   = 3'd6;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_burst_if.sv
// rtl/spi_slave_burst_if.sv - SPI slave front-end with burst frames, read-back serialiser and abort/timeout errors
module spi_slave_burst_if
   import spi_slave_burst_if_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int BURST_EN   = 1,
   parameter int TX_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ss_n,
   input  logic                  mosi,
   output logic                  miso,
   output logic [DATA_WIDTH+1:0] rx_data,
   output logic                  rx_valid,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  frame_err
);

   localparam int FRAME_LEN = DATA_WIDTH + 2;
   localparam int CW        = $clog2(DATA_WIDTH + 3);
   localparam int TW        = $clog2(TX_TIMEOUT + 1);

   localparam logic [CW-1:0] RX_LAST  = CW'(FRAME_LEN);
   localparam logic [CW-1:0] TX_LAST  = CW'(DATA_WIDTH);
   localparam logic [TW-1:0] TO_LIMIT = TW'(TX_TIMEOUT);

   state_t                 state;
   logic [CW-1:0]          bit_cnt;
   logic [TW-1:0]          to_cnt;
   logic [FRAME_LEN-1:0]   rx_sr;
   logic [DATA_WIDTH-1:0]  tx_sr;
   logic                   tx_busy;
   logic                   rd_addr_held;

   logic   rx_state;
   logic   rx_done;
   logic   tx_done;
   logic   in_frame;
   logic   abort;
   state_t end_state;

   // A frame that is finishing this cycle is not an abort: raising ss_n on the
   // completion cycle is the clean way to close a burst.
   assign rx_state  = (state == ST_WRITE) || (state == ST_READ_ADD) || (state == ST_READ_DATA);
   assign rx_done   = rx_state && (bit_cnt == RX_LAST);
   assign tx_done   = (state == ST_TX) && tx_busy && (bit_cnt == TX_LAST);
   assign in_frame  = (state != ST_IDLE) && (state != ST_WAIT_SS);
   assign abort     = ss_n && in_frame && !rx_done && !tx_done;
   assign end_state = ((BURST_EN != 0) && !ss_n) ? ST_CHK_CMD : ST_WAIT_SS;

   // Frame sequencer, shift registers, read-back serialiser and error strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         bit_cnt      <= '0;
         to_cnt       <= '0;
         rx_sr        <= '0;
         tx_sr        <= '0;
         tx_busy      <= 1'b0;
         rd_addr_held <= 1'b0;
         miso         <= 1'b0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         if (abort) begin
            state     <= ST_IDLE;
            frame_err <= 1'b1;
            miso      <= 1'b0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            tx_busy   <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (!ss_n) state <= ST_CHK_CMD;
               end
               ST_CHK_CMD: begin
                  bit_cnt <= '0;
                  if (!mosi)             state <= ST_WRITE;
                  else if (rd_addr_held) state <= ST_READ_DATA;
                  else                   state <= ST_READ_ADD;
               end
               ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                  if (!rx_done) begin
                     rx_sr   <= {rx_sr[FRAME_LEN-2:0], mosi};
                     bit_cnt <= bit_cnt + CW'(1);
                  end else begin
                     rx_valid <= 1'b1;
                     rx_data  <= rx_sr;
                     bit_cnt  <= '0;
                     to_cnt   <= '0;
                     tx_busy  <= 1'b0;
                     if (state == ST_READ_ADD)  rd_addr_held <= 1'b1;
                     if (state == ST_READ_DATA) rd_addr_held <= 1'b0;
                     state <= (state == ST_READ_DATA) ? ST_TX : end_state;
                  end
               end
               ST_TX: begin
                  if (!tx_busy) begin
                     if (tx_valid) begin
                        miso    <= tx_data[DATA_WIDTH-1];
                        tx_sr   <= {tx_data[DATA_WIDTH-2:0], 1'b0};
                        tx_busy <= 1'b1;
                        bit_cnt <= CW'(1);
                     end else if (to_cnt == TO_LIMIT) begin
                        frame_err <= 1'b1;
                        state     <= ST_WAIT_SS;
                     end else begin
                        to_cnt <= to_cnt + TW'(1);
                     end
                  end else if (!tx_done) begin
                     miso    <= tx_sr[DATA_WIDTH-1];
                     tx_sr   <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                     bit_cnt <= bit_cnt + CW'(1);
                  end else begin
                     miso    <= 1'b0;
                     tx_busy <= 1'b0;
                     bit_cnt <= '0;
                     state   <= end_state;
                  end
               end
               ST_WAIT_SS: begin
                  if (ss_n) state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
